// File: rtl/branch_redirect_controller_pkg.sv
// Shared pipeline types for the execute-stage redirect controller and its fetch-side consumers.
package branch_redirect_controller_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT     = 32;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;
  localparam int unsigned FLUSH_CNT_W          = 3;

  typedef enum logic [2:0] {
    TYPE_ALU   = 3'd0,
    TYPE_LOAD  = 3'd1,
    TYPE_STORE = 3'd2,
    TYPE_B     = 3'd3,
    TYPE_J     = 3'd4,
    TYPE_JALR  = 3'd5,
    TYPE_CSR   = 3'd6,
    TYPE_SYS   = 3'd7
  } op_type_e;

  typedef enum logic [1:0] {
    REDIRECT_IDLE  = 2'd0,
    REDIRECT_WAIT  = 2'd1,
    REDIRECT_DRAIN = 2'd2
  } redirect_state_e;

  // Redirect request as seen by fetch.
  typedef struct packed {
    logic                        valid;
    logic [PC_WIDTH_DEFAULT-1:0] pc;
  } redirect_req_t;

  // True when the op actually transfers control this cycle.
  function automatic logic ctrl_taken(input op_type_e op, input logic br_taken);
    return (op == TYPE_J) || (op == TYPE_JALR) || ((op == TYPE_B) && br_taken);
  endfunction

endpackage

// File: rtl/redirect_target_calc.sv
// Combinational target adder and redirect/misalign decision for the execute instruction.
// Optional BRANCH_PREDICT_EN: redirect only on mispredict, fall-through target pc+4.
module redirect_target_calc
  import branch_redirect_controller_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic                ex_valid_i,
  input  op_type_e            op_type_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [PC_WIDTH-1:0] op1_i,
  input  logic [PC_WIDTH-1:0] op2_i,
`ifdef BRANCH_PREDICT_EN
  input  logic                pred_taken_i,
  input  logic [PC_WIDTH-1:0] pred_target_i,
`endif
  output logic [PC_WIDTH-1:0] target_c,
  output logic [PC_WIDTH-1:0] redirect_pc_c,
  output logic                need_redirect_c,
  output logic                misaligned_c
);

  logic [PC_WIDTH-1:0] sum;
  logic                actual_taken;

  // Carry out of the add is dropped; JALR clears bit 0 of the sum.
  assign sum          = op1_i + op2_i;
  assign target_c     = (op_type_i == TYPE_JALR) ? {sum[PC_WIDTH-1:1], 1'b0} : sum;
  assign actual_taken = ex_valid_i && ctrl_taken(op_type_i, branch_taken_i);

`ifdef BRANCH_PREDICT_EN
  logic mispredict;

  assign mispredict      = (actual_taken != pred_taken_i) ||
                           (actual_taken && (target_c != pred_target_i));
  assign need_redirect_c = ex_valid_i && mispredict;
  assign redirect_pc_c   = actual_taken ? target_c : (pc_i + PC_WIDTH'(4));
  assign misaligned_c    = need_redirect_c && actual_taken && target_c[1];
`else
  logic unused_pc;

  // Static not-taken: only the taken path ever needs a redirect.
  assign unused_pc       = ^pc_i;
  assign need_redirect_c = actual_taken;
  assign redirect_pc_c   = target_c;
  assign misaligned_c    = actual_taken && target_c[1];
`endif

endmodule

// File: rtl/branch_redirect_controller.sv
// Execute-stage control-flow resolution: registered fetch redirect with handshake, front-end squash
// and execute stall, or misaligned-target exception. Optional macro: BRANCH_PREDICT_EN.
module branch_redirect_controller
  import branch_redirect_controller_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                exValid,
  input  op_type_e            opType,
  input  logic                branchTaken,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] irregPcOp1,
  input  logic [PC_WIDTH-1:0] irregPcOp2,
`ifdef BRANCH_PREDICT_EN
  input  logic                predTaken,
  input  logic [PC_WIDTH-1:0] predTarget,
`endif
  input  logic                trapFlush,
  input  logic                redirectReady,
  output logic                redirectValid,
  output logic [PC_WIDTH-1:0] redirectPc,
  output logic                flushFront,
  output logic                exStall,
  output logic                misalignExcValid,
  output logic [PC_WIDTH-1:0] misalignExcTval
);

  localparam bit HAS_DRAIN = (FLUSH_CYCLES != 0);

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                need_redirect;
  logic                misaligned;

  redirect_state_e         state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    rdr_valid_q, rdr_valid_d;
  logic [PC_WIDTH-1:0]     rdr_pc_q, rdr_pc_d;
  logic                    flush_q, flush_d;
  logic                    stall_q, stall_d;
  logic                    exc_valid_q, exc_valid_d;
  logic [PC_WIDTH-1:0]     exc_tval_q, exc_tval_d;

  redirect_target_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target_calc (
    .ex_valid_i      (exValid),
    .op_type_i       (opType),
    .branch_taken_i  (branchTaken),
    .pc_i            (pc),
    .op1_i           (irregPcOp1),
    .op2_i           (irregPcOp2),
`ifdef BRANCH_PREDICT_EN
    .pred_taken_i    (predTaken),
    .pred_target_i   (predTarget),
`endif
    .target_c        (target),
    .redirect_pc_c   (redirect_pc),
    .need_redirect_c (need_redirect),
    .misaligned_c    (misaligned)
  );

  // Next-state and next-output logic; every output falls to 0 unless a state holds it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdr_valid_d = 1'b0;
    rdr_pc_d    = '0;
    flush_d     = 1'b0;
    stall_d     = 1'b0;
    exc_valid_d = 1'b0;
    exc_tval_d  = '0;

    if (trapFlush) begin
      // Trap/CSR redirect wins: drop any pending redirect without a handshake.
      state_d = REDIRECT_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        REDIRECT_IDLE: begin
          if (need_redirect && !misaligned) begin
            state_d     = REDIRECT_WAIT;
            rdr_valid_d = 1'b1;
            rdr_pc_d    = redirect_pc;
            flush_d     = 1'b1;
            stall_d     = 1'b1;
          end else if (misaligned) begin
            exc_valid_d = 1'b1;
            exc_tval_d  = target;
          end
        end

        REDIRECT_WAIT: begin
          if (rdr_valid_q && redirectReady) begin
            if (HAS_DRAIN) begin
              state_d = REDIRECT_DRAIN;
              cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
              flush_d = 1'b1;
              stall_d = 1'b1;
            end else begin
              state_d = REDIRECT_IDLE;
            end
          end else begin
            rdr_valid_d = 1'b1;
            rdr_pc_d    = rdr_pc_q;
            flush_d     = 1'b1;
            stall_d     = 1'b1;
          end
        end

        REDIRECT_DRAIN: begin
          if (cnt_q == '0) begin
            state_d = REDIRECT_IDLE;
          end else begin
            cnt_d   = cnt_q - FLUSH_CNT_W'(1);
            flush_d = 1'b1;
            stall_d = 1'b1;
          end
        end

        default: begin
          state_d = REDIRECT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= REDIRECT_IDLE;
      cnt_q       <= '0;
      rdr_valid_q <= 1'b0;
      rdr_pc_q    <= '0;
      flush_q     <= 1'b0;
      stall_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_tval_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdr_valid_q <= rdr_valid_d;
      rdr_pc_q    <= rdr_pc_d;
      flush_q     <= flush_d;
      stall_q     <= stall_d;
      exc_valid_q <= exc_valid_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

  assign redirectValid    = rdr_valid_q;
  assign redirectPc       = rdr_pc_q;
  assign flushFront       = flush_q;
  assign exStall          = stall_q;
  assign misalignExcValid = exc_valid_q;
  assign misalignExcTval  = exc_tval_q;

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Self-checking bench: vector table, directed multi-cycle sequences and random stimulus vs. a reference model.
module tb_branch_redirect_controller;
  import branch_redirect_controller_pkg::*;

  localparam int unsigned PW = 32;
  localparam int unsigned FC = 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic          exValid;
  op_type_e      opType;
  logic          branchTaken;
  logic [PW-1:0] pc;
  logic [PW-1:0] irregPcOp1;
  logic [PW-1:0] irregPcOp2;
  logic          predTaken;
  logic [PW-1:0] predTarget;
  logic          trapFlush;
  logic          redirectReady;

  logic          redirectValid, flushFront, exStall, misalignExcValid;
  logic [PW-1:0] redirectPc, misalignExcTval;
  logic          z_valid, z_flush, z_stall, z_exc;
  logic [PW-1:0] z_pc, z_tval;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: waiting for handshake, drain cycles left, latched target, exception pulse.
  bit          m_wait;
  int          m_drain;
  logic [31:0] m_pc;
  bit          m_exc;
  logic [31:0] m_tval;

  always #5 clk = ~clk;

  branch_redirect_controller #(.PC_WIDTH(PW), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rstN             (rstN),
    .exValid          (exValid),
    .opType           (opType),
    .branchTaken      (branchTaken),
    .pc               (pc),
    .irregPcOp1       (irregPcOp1),
    .irregPcOp2       (irregPcOp2),
`ifdef BRANCH_PREDICT_EN
    .predTaken        (predTaken),
    .predTarget       (predTarget),
`endif
    .trapFlush        (trapFlush),
    .redirectReady    (redirectReady),
    .redirectValid    (redirectValid),
    .redirectPc       (redirectPc),
    .flushFront       (flushFront),
    .exStall          (exStall),
    .misalignExcValid (misalignExcValid),
    .misalignExcTval  (misalignExcTval)
  );

  branch_redirect_controller #(.PC_WIDTH(PW), .FLUSH_CYCLES(0)) dut0 (
    .clk              (clk),
    .rstN             (rstN),
    .exValid          (exValid),
    .opType           (opType),
    .branchTaken      (branchTaken),
    .pc               (pc),
    .irregPcOp1       (irregPcOp1),
    .irregPcOp2       (irregPcOp2),
`ifdef BRANCH_PREDICT_EN
    .predTaken        (predTaken),
    .predTarget       (predTarget),
`endif
    .trapFlush        (trapFlush),
    .redirectReady    (redirectReady),
    .redirectValid    (z_valid),
    .redirectPc       (z_pc),
    .flushFront       (z_flush),
    .exStall          (z_stall),
    .misalignExcValid (z_exc),
    .misalignExcTval  (z_tval)
  );

  typedef struct {
    string       name;
    op_type_e    op;
    logic        ev;
    logic        bt;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        trap;
    logic        exp_rv;
    logic [31:0] exp_pc;
    logic        exp_exc;
    logic [31:0] exp_tval;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input op_type_e op, input logic ev, input logic bt,
                              input logic [31:0] op1, input logic [31:0] op2, input logic trap,
                              input logic exp_rv, input logic [31:0] exp_pc,
                              input logic exp_exc, input logic [31:0] exp_tval);
    vec_t v;
    v.name = name; v.op = op; v.ev = ev; v.bt = bt; v.op1 = op1; v.op2 = op2; v.trap = trap;
    v.exp_rv = exp_rv; v.exp_pc = exp_pc; v.exp_exc = exp_exc; v.exp_tval = exp_tval;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model advance for one clock edge, using the inputs present at that edge.
  task automatic model_step();
    longint unsigned s;
    bit taken;
    m_exc = 1'b0;
    if (!rstN || trapFlush) begin
      m_wait  = 1'b0;
      m_drain = 0;
    end else if (m_wait) begin
      if (redirectReady) begin
        m_wait  = 1'b0;
        m_drain = FC;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else begin
      s = (64'(irregPcOp1) + 64'(irregPcOp2)) % (64'd1 << 32);
      if (opType == TYPE_JALR) s = s - (s % 2);
      taken = exValid && (opType == TYPE_J || opType == TYPE_JALR || (opType == TYPE_B && branchTaken));
      if (taken) begin
        if ((s / 2) % 2 == 1) begin
          m_exc  = 1'b1;
          m_tval = 32'(s);
        end else begin
          m_wait = 1'b1;
          m_pc   = 32'(s);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("redirectValid", 32'(redirectValid), 32'(m_wait));
    chk("flushFront", 32'(flushFront), 32'(m_wait || m_drain > 0));
    chk("exStall", 32'(exStall), 32'(m_wait || m_drain > 0));
    chk("misalignExcValid", 32'(misalignExcValid), 32'(m_exc));
    if (m_wait) chk("redirectPc", redirectPc, m_pc);
    if (m_exc) chk("misalignExcTval", misalignExcTval, m_tval);
  endtask

  task automatic set_idle();
    exValid = 1'b0; opType = TYPE_ALU; branchTaken = 1'b0; pc = '0;
    irregPcOp1 = '0; irregPcOp2 = '0; trapFlush = 1'b0; redirectReady = 1'b1;
    predTaken = 1'b0; predTarget = '0;
  endtask

  task automatic issue(input op_type_e op, input logic bt, input logic [31:0] op1, input logic [31:0] op2);
    exValid = 1'b1; opType = op; branchTaken = bt; pc = op1; irregPcOp1 = op1; irregPcOp2 = op2;
  endtask

  initial begin
    int hi;
    set_idle();
    rstN = 1'b0;
    step();
    step();
    chk("reset/redirectPc", redirectPc, 32'h0);
    chk("reset/misalignExcTval", misalignExcTval, 32'h0);
    chk("reset/z_outputs", {28'h0, z_valid, z_flush, z_stall, z_exc}, 32'h0);
    rstN = 1'b1;
    step();

    vq.push_back(mk("j_basic",     TYPE_J,    1, 0, 32'h100,      32'h40,       0, 1, 32'h140, 0, 32'h0));
    vq.push_back(mk("jalr_misal",  TYPE_JALR, 1, 0, 32'h2003,     32'h0,        0, 0, 32'h0,   1, 32'h2002));
    vq.push_back(mk("jalr_clr0",   TYPE_JALR, 1, 0, 32'h2001,     32'h0,        0, 1, 32'h2000, 0, 32'h0));
    vq.push_back(mk("b_nottaken",  TYPE_B,    1, 0, 32'h80,       32'h100,      0, 0, 32'h0,   0, 32'h0));
    vq.push_back(mk("b_wrap",      TYPE_B,    1, 1, 32'h80,       32'hFFFFFFF8, 0, 1, 32'h78,  0, 32'h0));
    vq.push_back(mk("b_wrap_hi",   TYPE_B,    1, 1, 32'hFFFFFFF0, 32'h20,       0, 1, 32'h10,  0, 32'h0));
    vq.push_back(mk("alu_none",    TYPE_ALU,  1, 1, 32'h100,      32'h40,       0, 0, 32'h0,   0, 32'h0));
    vq.push_back(mk("j_novalid",   TYPE_J,    0, 0, 32'h100,      32'h40,       0, 0, 32'h0,   0, 32'h0));
    vq.push_back(mk("j_trap",      TYPE_J,    1, 0, 32'h100,      32'h40,       1, 0, 32'h0,   0, 32'h0));
    vq.push_back(mk("j_misal",     TYPE_J,    1, 0, 32'h100,      32'h6,        0, 0, 32'h0,   1, 32'h106));
    vq.push_back(mk("j_misal_trap",TYPE_J,    1, 0, 32'h100,      32'h6,        1, 0, 32'h0,   0, 32'h0));
    vq.push_back(mk("j_odd_ok",    TYPE_J,    1, 0, 32'h101,      32'h0,        0, 1, 32'h101, 0, 32'h0));

    foreach (vq[i]) begin
      set_idle();
      exValid = vq[i].ev; opType = vq[i].op; branchTaken = vq[i].bt; pc = vq[i].op1;
      irregPcOp1 = vq[i].op1; irregPcOp2 = vq[i].op2; trapFlush = vq[i].trap;
      step();
      chk({vq[i].name, "/rv"}, 32'(redirectValid), 32'(vq[i].exp_rv));
      chk({vq[i].name, "/stall"}, 32'(exStall), 32'(vq[i].exp_rv));
      chk({vq[i].name, "/exc"}, 32'(misalignExcValid), 32'(vq[i].exp_exc));
      if (vq[i].exp_rv) chk({vq[i].name, "/pc"}, redirectPc, vq[i].exp_pc);
      if (vq[i].exp_exc) chk({vq[i].name, "/tval"}, misalignExcTval, vq[i].exp_tval);
      set_idle();
      repeat (4) step();
    end

    // Squash/stall window spans one handshake cycle plus the drain.
    set_idle();
    issue(TYPE_J, 1'b0, 32'h100, 32'h40);
    hi = 0;
    step();
    if (flushFront) hi++;
    exValid = 1'b0;
    repeat (5) begin
      step();
      if (flushFront) hi++;
    end
    chk("flush_window_len", 32'(hi), 32'd3);
    chk("idle_after_seq", {29'h0, redirectValid, flushFront, exStall}, 32'h0);

    // Backpressure: redirect held stable, new execute instructions ignored.
    issue(TYPE_J, 1'b0, 32'h100, 32'h40);
    redirectReady = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      issue(TYPE_J, 1'b0, 32'($urandom) & 32'hFFFF_FFF0, 32'h8);
      exValid = 1'($urandom_range(0, 1));
      step();
      chk("wait/redirectPc", redirectPc, 32'h140);
      chk("wait/redirectValid", 32'(redirectValid), 32'd1);
      chk("wait/exStall", 32'(exStall), 32'd1);
    end
    set_idle();
    step();
    chk("wait/drop_after_hs", 32'(redirectValid), 32'd0);
    repeat (3) step();

    // Trap during the second redirect cycle.
    issue(TYPE_J, 1'b0, 32'h100, 32'h40);
    redirectReady = 1'b0;
    step();
    exValid = 1'b0;
    step();
    trapFlush = 1'b1;
    step();
    chk("trap/outputs", {28'h0, redirectValid, flushFront, exStall, misalignExcValid}, 32'h0);
    chk("trap/redirectPc", redirectPc, 32'h0);
    trapFlush = 1'b0;
    redirectReady = 1'b1;
    step();
    chk("trap/no_replay", 32'(redirectValid), 32'd0);

    // Reset while draining.
    issue(TYPE_J, 1'b0, 32'h100, 32'h40);
    step();
    exValid = 1'b0;
    step();
    chk("drain/flushFront", 32'(flushFront), 32'd1);
    rstN = 1'b0;
    step();
    chk("rst_drain/outputs", {28'h0, redirectValid, flushFront, exStall, misalignExcValid}, 32'h0);
    chk("rst_drain/redirectPc", redirectPc, 32'h0);
    rstN = 1'b1;
    step();

    // Zero-drain instance returns to idle straight after the handshake.
    issue(TYPE_J, 1'b0, 32'h100, 32'h40);
    step();
    chk("fc0/valid", 32'(z_valid), 32'd1);
    chk("fc0/pc", z_pc, 32'h140);
    chk("fc0/stall", 32'(z_stall), 32'd1);
    exValid = 1'b0;
    step();
    chk("fc0/idle", {29'h0, z_valid, z_flush, z_stall}, 32'h0);
    issue(TYPE_J, 1'b0, 32'h200, 32'h10);
    step();
    chk("fc0/back_to_back", z_pc, 32'h210);
    chk("fc0/valid2", 32'(z_valid), 32'd1);
    set_idle();
    repeat (4) step();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      exValid       = 1'($urandom_range(0, 1));
      opType        = op_type_e'(3'($urandom_range(0, 7)));
      branchTaken   = 1'($urandom_range(0, 1));
      irregPcOp1    = $urandom;
      irregPcOp1[1:0] = 2'($urandom_range(0, 3));
      irregPcOp2    = $urandom & 32'hFFFF_FFFC;
      pc            = irregPcOp1;
      redirectReady = ($urandom_range(0, 9) < 6);
      trapFlush     = ($urandom_range(0, 19) == 0);
      rstN          = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_controller.md
Name: branch_redirect_controller

Overview:
- Sequences control-flow resolution in the execute stage.
- Consumes the irregular-PC operand pair (irregPcOp1, irregPcOp2) and the op type for the instruction in execute, then computes the resolved target.
- On a taken branch or jump, issues a registered redirect to fetch with a valid/ready handshake, squashes wrong-path front-end stages, and stalls execute until the redirect sequence completes.
- Misaligned targets are reported as an exception instead of a redirect.

Parameters:
- PC_WIDTH, 32, width of PC and target values.
- FLUSH_CYCLES, 2, front-end squash cycles held after the fetch handshake (0..7).

Ports:
- clk  input  1  core clock
- rstN  input  1  reset; synchronous, active-low
- exValid  input  1  valid instruction in execute this cycle
- opType  input  OpType  decoded type (TYPE_B, TYPE_J, TYPE_JALR, other)
- branchTaken  input  1  branch comparison result (meaningful for TYPE_B only)
- pc  input  PC_WIDTH  PC of the execute instruction
- irregPcOp1  input  PC_WIDTH  target base (pc or rs1)
- irregPcOp2  input  PC_WIDTH  target offset (imm or 4)
- trapFlush  input  1  higher-priority redirect from trap/CSR unit
- redirectReady  input  1  fetch accepts redirect
- redirectValid  output  1  redirect request to fetch
- redirectPc  output  PC_WIDTH  redirect target
- flushFront  output  1  squash IF/ID wrong-path instructions
- exStall  output  1  hold execute stage
- misalignExcValid  output  1  one-cycle misaligned-target exception pulse
- misalignExcTval  output  PC_WIDTH  faulting target

Behaviour:
- Reset (rstN=0 at clk edge): state IDLE, counter 0, and every output 0, including redirectPc and misalignExcTval.
- Target calculation:
  - target = irregPcOp1 + irregPcOp2, modulo 2^PC_WIDTH; carry discarded.
  - For TYPE_JALR, target[0] is forced to 0.
- needRedirect = exValid && (opType==TYPE_J || opType==TYPE_JALR || (opType==TYPE_B && branchTaken)).
- misaligned = needRedirect && target[1].
- State IDLE:
  - needRedirect && !misaligned && !trapFlush: latch redirectPc=target and go to REDIRECT. Starting next cycle, redirectValid=1, flushFront=1, exStall=1. Latency is exactly 1 cycle.
  - misaligned && !trapFlush: next cycle misalignExcValid=1 for exactly one cycle, misalignExcTval=target; state stays IDLE; no redirect and no stall.
  - Otherwise all outputs are 0.
- State REDIRECT:
  - redirectValid, redirectPc, flushFront and exStall are held stable until the handshake.
  - redirectValid && redirectReady: the handshake completes.
    - If FLUSH_CYCLES>0, go to DRAIN with count=FLUSH_CYCLES-1.
    - If FLUSH_CYCLES==0, go to IDLE.
  - redirectValid drops in the cycle after the handshake.
- State DRAIN:
  - redirectValid=0, flushFront=1, exStall=1.
  - The count decrements each cycle; at count==0 the next state is IDLE.
  - DRAIN therefore lasts exactly FLUSH_CYCLES cycles.
- exValid while not IDLE is ignored; upstream holds the instruction because exStall=1.
- trapFlush has priority in every state. Next state is IDLE; all outputs are cleared next cycle; a pending redirect is dropped without a handshake.
  - In IDLE, trapFlush suppresses both the redirect and the exception from the same cycle.
- Non-control ops (other opType) never redirect; the not-taken fall-through needs no action.
- Reset mid-sequence returns to IDLE with all outputs 0 on that edge.

Optional Feature:
- Macro: BRANCH_PREDICT_EN.
- Defined: adds inputs predTaken (1) and predTarget (PC_WIDTH).
  - Redirect is required only on mispredict: actual taken != predTaken, or both taken with target != predTarget.
  - When predicted taken but actually not taken, redirectPc = pc + 4.
  - Misalign checks apply only to the actual-taken path.
- Undefined: static not-taken. Every taken control transfer redirects, as specified above.

Decomposition:
- Shared package (PipelineTypes) holds:
  - RedirectState enum (REDIRECT_IDLE, REDIRECT_WAIT, REDIRECT_DRAIN).
  - FLUSH_CYCLES_DEFAULT constant.
  - RedirectReq struct {valid, pc}, for reuse by fetch.
- OpType and PC come from the existing packages.
- One sub-module is natural: redirect_target_calc. It is purely combinational and computes target, needRedirect and misaligned (plus the mispredict compare under BRANCH_PREDICT_EN).

Test Plan:
- TYPE_J, pc=0x100, op1=0x100, op2=0x40, redirectReady=1 -> next cycle redirectValid=1, redirectPc=0x140; flushFront/exStall high for 1+2 cycles; IDLE afterward.
- TYPE_JALR, op1=0x2003, op2=0x0 -> target 0x2002 with bit1 set, so misalignExcValid pulses 1 cycle with tval=0x2002; no redirect. Second case: op1=0x2001 -> redirectPc=0x2000.
- TYPE_B with branchTaken=0 -> no output activity. TYPE_B taken, op1=0x80, op2=0xFFFFFFF8 -> redirectPc=0x78 (wrap-add).
- redirectReady held 0 for 5 cycles -> redirectValid and redirectPc=0x140 stable and exStall=1 throughout; exValid pulses during the wait are ignored.
- trapFlush asserted in the second REDIRECT cycle -> next cycle all outputs 0, state IDLE, with no handshake.
- rstN=0 asserted in DRAIN -> next cycle all outputs 0. With FLUSH_CYCLES=0, redirect goes directly to IDLE after the handshake.
